// File: rtl/video_timing_gen_if.sv
// ============================================================================
// Module      : video_timing_gen_if
// Description : Raster timing bundle between the timing generator and its
//               consumers (pixel_gen, DAC sync pins).
//               master : timing generator (drives the raster, samples en)
//               slave  : consumer (drives en, samples the raster)
// Signals     : en          pixel-clock enable, counters advance only when 1
//               pixel_cnt   horizontal position, 0..H_TOTAL-1
//               line_cnt    vertical position, 0..V_TOTAL-1
//               h_sync      horizontal sync, polarity H_POL
//               v_sync      vertical sync, polarity V_POL
//               video_on    visible-region flag
//               line_start  1-cycle pulse when pixel_cnt becomes 0
//               frame_start 1-cycle pulse when the raster becomes (0, 0)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface video_timing_gen_if;
  logic        en;
  logic [11:0] pixel_cnt;
  logic [11:0] line_cnt;
  logic        h_sync;
  logic        v_sync;
  logic        video_on;
  logic        line_start;
  logic        frame_start;

  modport master (
    input  en,
    output pixel_cnt,
    output line_cnt,
    output h_sync,
    output v_sync,
    output video_on,
    output line_start,
    output frame_start
  );

  modport slave (
    output en,
    input  pixel_cnt,
    input  line_cnt,
    input  h_sync,
    input  v_sync,
    input  video_on,
    input  line_start,
    input  frame_start
  );
endinterface

`default_nettype wire

// File: rtl/video_timing_gen.sv
// ============================================================================
// Module      : video_timing_gen
// Description : Raster timing source for one display mode. A horizontal and a
//               vertical FSM each walk ACTIVE -> FRONT_PORCH -> SYNC ->
//               BACK_PORCH. Every output is registered and derived from the
//               next-count value, so it is cycle-aligned with the counters.
// Ports       : rfr_clk  in  pixel/refresh clock
//               reset_n  in  asynchronous active-low reset
//               vt_if    master modport of video_timing_gen_if
//                        (en in; pixel_cnt, line_cnt, h_sync, v_sync,
//                         video_on, line_start, frame_start out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0
) (
  input  wire logic           rfr_clk,
  input  wire logic           reset_n,
  video_timing_gen_if.master  vt_if
);

  // --------------------------------------------------------------------------
  // Raster geometry
  // --------------------------------------------------------------------------
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Segment boundaries are 13 bits wide: with a zero back porch the BP
  // boundary equals the total, which may be exactly 4096 and must never
  // alias onto count 0.
  localparam logic [12:0] H_FP_START   = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_START = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_BP_START   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);

  localparam logic [12:0] V_FP_START   = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYNC_START = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_BP_START   = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);

  // --------------------------------------------------------------------------
  // FSM encoding (shared by the horizontal and vertical machines)
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_FP     = 2'd1;
  localparam logic [1:0] ST_SYNC   = 2'd2;
  localparam logic [1:0] ST_BP     = 2'd3;

  // --------------------------------------------------------------------------
  // Geometry sanity: counters are 12 bits
  // --------------------------------------------------------------------------
  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_check
    $error("video_timing_gen: H_TOTAL or V_TOTAL exceeds 4096");
  end

  // --------------------------------------------------------------------------
  // Segment walk: the state changes when the next count lands on a segment
  // boundary. The checks run in raster order so that, when a zero-width
  // segment makes two boundaries coincide, the later segment wins and the
  // empty one is skipped.
  // --------------------------------------------------------------------------
  function automatic logic [1:0] seg_next(
    input logic [1:0]  cur,
    input logic [11:0] cnt,
    input logic [12:0] fp_start,
    input logic [12:0] sync_start,
    input logic [12:0] bp_start
  );
    logic [1:0]  nxt;
    logic [12:0] cnt_x;
    nxt   = cur;
    cnt_x = {1'b0, cnt};
    if (cnt == 12'd0)        nxt = ST_ACTIVE;
    if (cnt_x == fp_start)   nxt = ST_FP;
    if (cnt_x == sync_start) nxt = ST_SYNC;
    if (cnt_x == bp_start)   nxt = ST_BP;
    return nxt;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [11:0] pixel_q,  pixel_d;
  logic [11:0] line_q,   line_d;
  logic [1:0]  hstate_q, hstate_d;
  logic [1:0]  vstate_q, vstate_d;
  logic        hsync_q,  hsync_d;
  logic        vsync_q,  vsync_d;
  logic        video_q,  video_d;
  logic        lstart_q, lstart_d;
  logic        fstart_q, fstart_d;

  logic        h_wrap;
  logic        v_wrap;
  logic        line_adv;

  assign h_wrap   = (pixel_q == H_LAST);
  assign v_wrap   = (line_q == V_LAST);
  // The vertical side only moves on an enabled horizontal wrap.
  assign line_adv = vt_if.en && h_wrap;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    pixel_d  = pixel_q;
    line_d   = line_q;
    hstate_d = hstate_q;
    vstate_d = vstate_q;

    if (vt_if.en) begin
      pixel_d  = h_wrap ? 12'd0 : pixel_q + 12'd1;
      hstate_d = seg_next(hstate_q, pixel_d,
                          H_FP_START, H_SYNC_START, H_BP_START);
    end

    if (line_adv) begin
      line_d   = v_wrap ? 12'd0 : line_q + 12'd1;
      vstate_d = seg_next(vstate_q, line_d,
                          V_FP_START, V_SYNC_START, V_BP_START);
    end
  end

  // Outputs are decoded from the next state so that they land on the same
  // edge as the counter value they describe. With en low the states hold,
  // so these decodes hold too; the pulses are gated by en explicitly.
  always_comb begin
    hsync_d  = (hstate_d == ST_SYNC) ? H_POL : ~H_POL;
    vsync_d  = (vstate_d == ST_SYNC) ? V_POL : ~V_POL;
    video_d  = (hstate_d == ST_ACTIVE) && (vstate_d == ST_ACTIVE);
    lstart_d = line_adv;
    fstart_d = line_adv && v_wrap;
  end

  // --------------------------------------------------------------------------
  // Registers. Reset parks the raster on its last pixel so the first enabled
  // edge afterwards lands on (0, 0) with both start pulses.
  // --------------------------------------------------------------------------
  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_q  <= H_LAST;
      line_q   <= V_LAST;
      hstate_q <= ST_BP;
      vstate_q <= ST_BP;
      hsync_q  <= ~H_POL;
      vsync_q  <= ~V_POL;
      video_q  <= 1'b0;
      lstart_q <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      pixel_q  <= pixel_d;
      line_q   <= line_d;
      hstate_q <= hstate_d;
      vstate_q <= vstate_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      video_q  <= video_d;
      lstart_q <= lstart_d;
      fstart_q <= fstart_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign vt_if.pixel_cnt   = pixel_q;
  assign vt_if.line_cnt    = line_q;
  assign vt_if.h_sync      = hsync_q;
  assign vt_if.v_sync      = vsync_q;
  assign vt_if.video_on    = video_q;
  assign vt_if.line_start  = lstart_q;
  assign vt_if.frame_start = fstart_q;

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Directed self-checking bench for video_timing_gen. One
//               instance uses the default 640x480 mode for reset and line-level
//               timing; a second, tiny mode (16x11, H_POL=1, zero vertical
//               front porch) covers frame wrap, en toggling and mid-frame
//               reset in a few hundred cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_timing_gen;

  logic rfr_clk;
  logic reset_n;

  video_timing_gen_if if_def ();
  video_timing_gen_if if_sm ();

  // Default 640x480 mode
  video_timing_gen u_def (
    .rfr_clk (rfr_clk),
    .reset_n (reset_n),
    .vt_if   (if_def)
  );

  // Small mode: H 8/2/3/3 (16), V 6/0/2/3 (11); h_sync active-high
  video_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (0), .V_SYNC (2), .V_BP (3),
    .H_POL    (1'b1), .V_POL (1'b0)
  ) u_sm (
    .rfr_clk (rfr_clk),
    .reset_n (reset_n),
    .vt_if   (if_sm)
  );

  initial begin
    rfr_clk = 1'b0;
    forever #5 rfr_clk = ~rfr_clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge rfr_clk);
    #1;
  endtask

  // Small-mode reference model
  int m_px, m_ln;
  bit m_ls, m_fs;
  int bad_cnt, bad_hs, bad_vs, bad_vo, bad_pulse;

  task automatic model_step(input bit adv);
    bit wrap;
    m_ls = 1'b0;
    m_fs = 1'b0;
    if (adv) begin
      wrap = (m_px == 15);
      m_px = wrap ? 0 : m_px + 1;
      if (wrap) m_ln = (m_ln == 10) ? 0 : m_ln + 1;
      m_ls = wrap;
      m_fs = wrap && (m_ln == 0);
    end
  endtask

  task automatic sm_compare;
    bit e_hs, e_vs, e_vo;
    e_hs = (m_px >= 10 && m_px <= 12);
    e_vs = !(m_ln >= 6 && m_ln <= 7);
    e_vo = (m_px < 8) && (m_ln < 6);
    if (if_sm.pixel_cnt !== 12'(m_px) || if_sm.line_cnt !== 12'(m_ln)) bad_cnt++;
    if (if_sm.h_sync !== e_hs) bad_hs++;
    if (if_sm.v_sync !== e_vs) bad_vs++;
    if (if_sm.video_on !== e_vo) bad_vo++;
    if (if_sm.line_start !== m_ls || if_sm.frame_start !== m_fs) bad_pulse++;
  endtask

  int  hs_low, hs_first, hs_last, ls_n, fs_n, vs_low;
  int  fs_k0, fs_k1, pulse_hold;
  bit  found;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    if_def.en   = 1'b0;
    if_sm.en    = 1'b0;
    repeat (3) tick;

    // ---------------- reset values ----------------
    check("def_rst_px", if_def.pixel_cnt, 799);
    check("def_rst_ln", if_def.line_cnt, 524);
    check("def_rst_hs", if_def.h_sync, 1);
    check("def_rst_vs", if_def.v_sync, 1);
    check("def_rst_vo", if_def.video_on, 0);
    check("def_rst_ls", if_def.line_start, 0);
    check("def_rst_fs", if_def.frame_start, 0);
    check("sm_rst_px", if_sm.pixel_cnt, 15);
    check("sm_rst_ln", if_sm.line_cnt, 10);
    check("sm_rst_hs", if_sm.h_sync, 0);
    check("sm_rst_vs", if_sm.v_sync, 1);

    // ---------------- default mode: first edge ----------------
    @(negedge rfr_clk);
    reset_n   = 1'b1;
    if_def.en = 1'b1;
    tick;
    check("def_first_px", if_def.pixel_cnt, 0);
    check("def_first_ln", if_def.line_cnt, 0);
    check("def_first_vo", if_def.video_on, 1);
    check("def_first_ls", if_def.line_start, 1);
    check("def_first_fs", if_def.frame_start, 1);
    check("def_first_hs", if_def.h_sync, 1);
    check("sm_held_px", if_sm.pixel_cnt, 15);

    // ---------------- default mode: two-line sweep ----------------
    bad_cnt = 0; bad_vo = 0; hs_low = 0; hs_first = -1; hs_last = -1;
    ls_n = 0; fs_n = 0; vs_low = 0;
    for (int k = 1; k <= 1600; k++) begin
      tick;
      if (if_def.pixel_cnt !== 12'(k % 800) || if_def.line_cnt !== 12'(k / 800)) bad_cnt++;
      if (if_def.video_on !== ((k % 800) < 640)) bad_vo++;
      if (if_def.h_sync === 1'b0) begin
        hs_low++;
        if (k / 800 == 1) begin
          if (hs_first < 0) hs_first = k % 800;
          hs_last = k % 800;
        end
      end
      if (if_def.line_start === 1'b1) ls_n++;
      if (if_def.frame_start === 1'b1) fs_n++;
      if (if_def.v_sync === 1'b0) vs_low++;
      if (k == 639) check("def_vo_639", if_def.video_on, 1);
      if (k == 640) check("def_vo_640", if_def.video_on, 0);
      if (k == 800) begin
        check("def_l1_ln", if_def.line_cnt, 1);
        check("def_l1_ls", if_def.line_start, 1);
        check("def_l1_fs", if_def.frame_start, 0);
      end
    end
    check("def_cnt_track", bad_cnt, 0);
    check("def_vo_track", bad_vo, 0);
    check("def_hs_low", hs_low, 192);
    check("def_hs_first", hs_first, 656);
    check("def_hs_last", hs_last, 751);
    check("def_ls_count", ls_n, 2);
    check("def_fs_count", fs_n, 0);
    check("def_vs_low", vs_low, 0);

    // ---------------- small mode: first edge + two frames ----------------
    if_def.en = 1'b0;
    if_sm.en  = 1'b1;
    tick;
    check("sm_first_px", if_sm.pixel_cnt, 0);
    check("sm_first_ln", if_sm.line_cnt, 0);
    check("sm_first_fs", if_sm.frame_start, 1);
    check("sm_first_vo", if_sm.video_on, 1);
    m_px = 0; m_ln = 0;
    bad_cnt = 0; bad_hs = 0; bad_vs = 0; bad_vo = 0; bad_pulse = 0;
    fs_n = 0; vs_low = 0; fs_k0 = -1; fs_k1 = -1;
    for (int k = 1; k <= 352; k++) begin
      tick;
      model_step(1'b1);
      sm_compare();
      if (if_sm.v_sync === 1'b0) vs_low++;
      if (if_sm.frame_start === 1'b1) begin
        fs_n++;
        if (fs_k0 < 0) fs_k0 = k; else fs_k1 = k;
      end
      if (k == 176) begin
        check("sm_wrap_px", if_sm.pixel_cnt, 0);
        check("sm_wrap_ln", if_sm.line_cnt, 0);
        check("sm_wrap_ls", if_sm.line_start, 1);
        check("sm_wrap_fs", if_sm.frame_start, 1);
        check("sm_wrap_vs", if_sm.v_sync, 1);
      end
    end
    check("sm_cnt_track", bad_cnt, 0);
    check("sm_hs_track", bad_hs, 0);
    check("sm_vs_track", bad_vs, 0);
    check("sm_vo_track", bad_vo, 0);
    check("sm_pulse_track", bad_pulse, 0);
    check("sm_vs_low", vs_low, 64);
    check("sm_fs_count", fs_n, 2);
    check("sm_fs_period", fs_k1 - fs_k0, 176);

    // ---------------- small mode: en toggling ----------------
    bad_cnt = 0; bad_hs = 0; bad_vs = 0; bad_vo = 0; bad_pulse = 0;
    fs_n = 0; fs_k0 = -1; fs_k1 = -1; pulse_hold = 0;
    for (int k = 0; k < 704; k++) begin
      if_sm.en = (k % 2 == 1);
      tick;
      model_step(if_sm.en);
      sm_compare();
      if (!if_sm.en && (if_sm.line_start === 1'b1 || if_sm.frame_start === 1'b1)) pulse_hold++;
      if (if_sm.frame_start === 1'b1) begin
        fs_n++;
        if (fs_k0 < 0) fs_k0 = k; else fs_k1 = k;
      end
    end
    check("tog_cnt_track", bad_cnt, 0);
    check("tog_out_track", bad_hs + bad_vs + bad_vo, 0);
    check("tog_pulse_track", bad_pulse, 0);
    check("tog_pulse_hold", pulse_hold, 0);
    check("tog_fs_count", fs_n, 2);
    check("tog_fs_period", fs_k1 - fs_k0, 352);

    // ---------------- mid-frame asynchronous reset ----------------
    if_sm.en = 1'b1;
    found    = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      tick;
      model_step(1'b1);
      if (m_px == 5 && m_ln == 3) found = 1'b1;
    end
    check("sm_reach_53", found, 1);
    check("sm_pre_rst_px", if_sm.pixel_cnt, 5);
    check("sm_pre_rst_ln", if_sm.line_cnt, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("sm_async_px", if_sm.pixel_cnt, 15);
    check("sm_async_ln", if_sm.line_cnt, 10);
    check("sm_async_hs", if_sm.h_sync, 0);
    check("sm_async_vs", if_sm.v_sync, 1);
    check("sm_async_vo", if_sm.video_on, 0);
    check("sm_async_pulse", {if_sm.line_start, if_sm.frame_start}, 0);
    check("def_async_px", if_def.pixel_cnt, 799);
    tick;
    check("sm_rst_hold_px", if_sm.pixel_cnt, 15);
    @(negedge rfr_clk);
    reset_n   = 1'b1;
    if_def.en = 1'b1;
    tick;
    check("sm_restart_px", if_sm.pixel_cnt, 0);
    check("sm_restart_ln", if_sm.line_cnt, 0);
    check("sm_restart_fs", if_sm.frame_start, 1);
    check("def_restart_px", if_def.pixel_cnt, 0);
    check("def_restart_ln", if_def.line_cnt, 0);
    check("def_restart_fs", if_def.frame_start, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
